// File: rtl/lsu_dmem_master_pkg.sv
// Shared types and lane helpers for the LSU data-memory master.
package lsu_dmem_master_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

  // Captured request; the aligned word address lives in the dmem_addr register.
  typedef struct packed {
    logic              we;
    size_e             size;
    logic              uns;
    logic [1:0]        addr_lo;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  // Reserved size encoding behaves as a word access.
  function automatic logic size_is_word(input size_e size);
    return size[1];
  endfunction

  function automatic logic misaligned(input logic [1:0] addr_lo, input size_e size);
    return ((size == SZ_HALF) && addr_lo[0]) || (size_is_word(size) && (addr_lo != 2'b00));
  endfunction

  // Replace the addressed byte/half lanes of word with right-justified store data.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] word,
                                                   input logic [DATA_W-1:0] data,
                                                   input logic [1:0]        addr_lo,
                                                   input size_e             size);
    logic [DATA_W-1:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{addr_lo, 3'b000} +: 8]        = data[7:0];
      SZ_HALF: r[{addr_lo[1], 4'b0000} +: 16]   = data[15:0];
      default: r                                = data;
    endcase
    return r;
  endfunction

  // Pull the addressed lanes out of word and sign/zero extend to 32 bits.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0]        addr_lo,
                                                    input size_e             size,
                                                    input logic              uns);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{addr_lo, 3'b000} +: 8];
    h = word[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// Request/response handshake plus data-memory port of the LSU.
interface lsu_dmem_master_if
  import lsu_dmem_master_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;

  // The LSU side.
  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata
  );

  // CPU stage plus data memory.
  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata
  );

endinterface

// File: rtl/lsu_lane_unit.sv
// Combinational store-merge and load-extract on one memory word.
module lsu_lane_unit
  import lsu_dmem_master_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        addr_lo,
  input  size_e             size,
  input  logic              uns,
  output logic [DATA_W-1:0] merge_c,
  output logic [DATA_W-1:0] load_c
);

  // Both results are pure functions of the current memory word.
  assign merge_c = lane_merge(word, data, addr_lo, size);
  assign load_c  = load_extend(word, addr_lo, size, uns);

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store initiator: sub-word accesses become aligned word reads/writes.
module lsu_dmem_master
  import lsu_dmem_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  lsu_dmem_master_if.master   bus
);

  state_e            state_q;
  lsu_req_t          req_q;
  logic [DATA_W-1:0] merge_c;
  logic [DATA_W-1:0] load_c;
  logic              misaligned_c;

  assign misaligned_c = ALIGN_CHECK && misaligned(bus.req_addr[1:0], size_e'(bus.req_size));

  lsu_lane_unit u_lane (
    .word    (bus.dmem_rdata),
    .data    (req_q.wdata),
    .addr_lo (req_q.addr_lo),
    .size    (req_q.size),
    .uns     (req_q.uns),
    .merge_c (merge_c),
    .load_c  (load_c)
  );

  // Access sequencer; every handshake and memory output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            req_q.we      <= bus.req_we;
            req_q.size    <= size_e'(bus.req_size);
            req_q.uns     <= bus.req_unsigned;
            req_q.addr_lo <= bus.req_addr[1:0];
            req_q.wdata   <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (misaligned_c) begin
              // Error responses skip memory entirely.
              state_q        <= ST_RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              bus.dmem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (bus.req_we && bus.req_size[1]) begin
                state_q        <= ST_WRITE;
                bus.dmem_we    <= 1'b1;
                bus.dmem_wdata <= bus.req_wdata;
              end else begin
                state_q <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          if (req_q.we) begin
            // Sub-word store: merge into the word just read, write it back next cycle.
            state_q        <= ST_WRITE;
            bus.dmem_we    <= 1'b1;
            bus.dmem_wdata <= merge_c;
          end else begin
            state_q        <= ST_RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_c;
          end
        end
        ST_WRITE: begin
          state_q        <= ST_RESP;
          bus.dmem_we    <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state_q        <= ST_IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Randomized bench for lsu_dmem_master against a word-array memory reference.
module tb_lsu_dmem_master;
  import lsu_dmem_master_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned N_WORDS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  lsu_dmem_master_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_dmem_master #(.ADDR_W(ADDR_W), .ALIGN_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, one word write per clock, preload port for the bench.
  logic [31:0] mem     [N_WORDS];
  logic [31:0] ref_mem [N_WORDS];
  logic        pl_en   = 1'b0;
  logic [3:0]  pl_idx  = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (bus.dmem_we) mem[bus.dmem_addr[5:2]] <= bus.dmem_wdata;
  end
  assign bus.dmem_rdata = mem[bus.dmem_addr[5:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory described with shifts and masks.
  function automatic logic ref_mis(input int a, input int sz);
    return (sz == 1 && (a % 2) != 0) || (sz >= 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int a, input int sz, input logic u);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * (a % 4))) & 32'h000000FF;
      if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (((a % 4) >= 2) ? 16 : 0)) & 32'h0000FFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd, input int a, input int sz);
    logic [31:0] mask;
    int          sh;
    if (sz >= 2) return wd;
    sh   = (sz == 0) ? 8 * (a % 4) : (((a % 4) >= 2) ? 16 : 0);
    mask = ((sz == 0) ? 32'h000000FF : 32'h0000FFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = 4'(idx); pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic drive_req(input logic we, input int sz, input logic u, input int a, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = 2'(sz);
    bus.req_unsigned = u;
    bus.req_addr     = 32'(a);
    bus.req_wdata    = wd;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // One transaction from accept to release; called at posedge+1 with the DUT idle.
  task automatic xact(input logic we, input int sz, input logic u, input int a,
                      input logic [31:0] wd, input int hold, output logic [31:0] rdata);
    int          lat, we_cnt, we_cyc, i, idx, e_lat, e_we;
    logic [31:0] we_addr, e_rd;
    logic        e_err;
    lat = 0; we_cnt = 0; we_cyc = 0; we_addr = '0; i = 1;
    idx = a / 4;
    drive_req(we, sz, u, a, wd);
    while (lat == 0 && i <= 8) begin
      if (bus.dmem_we) begin we_cnt++; we_cyc = i; we_addr = bus.dmem_addr; end
      if (bus.resp_valid) lat = i;
      else begin @(posedge clk); #1; i++; end
    end
    rdata = bus.resp_rdata;
    e_err = ref_mis(a, sz);
    e_rd  = '0;
    e_we  = 0;
    if (e_err)   e_lat = 1;
    else if (!we) begin e_lat = 2; e_rd = ref_load(ref_mem[idx], a, sz, u); end
    else begin
      e_lat = (sz >= 2) ? 2 : 3;
      e_we  = 1;
      ref_mem[idx] = ref_store(ref_mem[idx], wd, a, sz);
    end
    check("resp_latency", 32'(lat), 32'(e_lat));
    if (lat == 0) begin
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      return;
    end
    check("resp_err", 32'(bus.resp_err), 32'(e_err));
    check("resp_rdata", bus.resp_rdata, e_rd);
    check("dmem_we_pulses", 32'(we_cnt), 32'(e_we));
    if (e_we == 1) begin
      check("dmem_we_cycle", 32'(we_cyc), 32'(e_lat - 1));
      check("dmem_we_addr", we_addr, 32'(idx * 4));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_rdata", bus.resp_rdata, e_rd);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_we", 32'(bus.dmem_we), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] rd;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < int'(N_WORDS); k++) preload(k, $urandom);
    preload(4, 32'hDEADBEEF);
    rst = 1'b0;

    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
    check("rst_dmem_addr", bus.dmem_addr, 32'd0);
    check("rst_dmem_wdata", bus.dmem_wdata, 32'd0);

    xact(1'b0, 0, 1'b0, 'h13, 32'd0, 0, rd); check("lb_13", rd, 32'hFFFFFFDE);
    xact(1'b0, 0, 1'b1, 'h13, 32'd0, 0, rd); check("lbu_13", rd, 32'h000000DE);
    xact(1'b0, 1, 1'b0, 'h12, 32'd0, 0, rd); check("lh_12", rd, 32'hFFFFDEAD);
    xact(1'b0, 1, 1'b1, 'h10, 32'd0, 0, rd); check("lhu_10", rd, 32'h0000BEEF);
    xact(1'b1, 0, 1'b0, 'h11, 32'h12345655, 0, rd);
    check("sb_rdata", rd, 32'd0);
    check("sb_mem", mem[4], 32'hDEAD55EF);

    preload(4, 32'hDEADBEEF);
    xact(1'b1, 1, 1'b0, 'h12, 32'h0000CAFE, 0, rd);
    xact(1'b0, 2, 1'b0, 'h10, 32'd0, 0, rd); check("sh_lw_10", rd, 32'hCAFEBEEF);
    xact(1'b1, 2, 1'b0, 'h14, 32'h01020304, 0, rd);
    xact(1'b0, 0, 1'b1, 'h15, 32'd0, 0, rd); check("sw_lbu_15", rd, 32'h00000003);

    xact(1'b1, 1, 1'b0, 'h11, 32'h0000BBBB, 0, rd); check("sh_mis_rdata", rd, 32'd0);
    xact(1'b0, 2, 1'b0, 'h12, 32'd0, 0, rd);        check("lw_mis_rdata", rd, 32'd0);

    preload(4, 32'hDEADBEEF);
    xact(1'b0, 2, 1'b0, 'h10, 32'd0, 5, rd); check("lw_hold", rd, 32'hDEADBEEF);

    // Reset while the read half of a byte store is in flight: nothing is written.
    drive_req(1'b1, 0, 1'b0, 'h10, 32'h000000AA);
    check("rst_rd_we", 32'(bus.dmem_we), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_rd_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rd_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    check("rst_rd_no_resp", 32'(bus.resp_valid), 32'd0);
    check("rst_rd_mem", mem[4], 32'hDEADBEEF);

    // Reset on the edge ending a write: the write still lands, no response follows.
    drive_req(1'b1, 2, 1'b0, 'h18, 32'h11223344);
    check("rst_wr_we", 32'(bus.dmem_we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[6] = 32'h11223344;
    check("rst_wr_mem", mem[6], 32'h11223344);
    check("rst_wr_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_wr_req_ready", 32'(bus.req_ready), 32'd1);

    for (int t = 0; t < 300; t++) begin
      xact(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 2)), rd);
    end
    for (int k = 0; k < int'(N_WORDS); k++) check("final_mem", mem[k], ref_mem[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store initiator between the CPU memory stage and the data memory.
- Data memory interface: byte-addressed, little-endian. One full 32-bit word write per clock when `we` is high. Combinational 32-bit read at `daddr`.
- This block turns byte, halfword and word loads/stores into aligned word accesses. Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Misaligned requests are flagged as errors and never reach memory.

Parameters:
- ADDR_W, 32, width of request and memory address.
- ALIGN_CHECK, 1, when 1 misaligned requests return resp_err; when 0 the low address bits are ignored and a word access is forced aligned.

Ports:
- clk  in  1  clock. One clock domain; the block and data memory both run on it.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is reserved and treated as word.
- req_unsigned  in  1  load zero-extend (lbu/lhu); ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access.
- dmem_we  out  1  memory write enable.
- dmem_addr  out  ADDR_W  word-aligned memory address (low 2 bits always 0).
- dmem_wdata  out  32  memory write word.
- dmem_rdata  in  32  memory read word.

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- Reset (sync, rst high at an edge): state goes to IDLE. All request captures clear. resp_valid, resp_err, resp_rdata, dmem_we, dmem_addr, dmem_wdata read 0. req_ready reads 1.
- Accept: on an edge with req_valid && req_ready, capture we, size, unsigned, addr, wdata.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0 (ALIGN_CHECK=1).
- Next state from IDLE on accept:
  - misaligned -> RESP, resp_err=1, no memory access;
  - load -> READ;
  - word store -> WRITE;
  - byte/half store -> READ.
- READ: dmem_addr = {addr[ADDR_W-1:2],2'b00}, dmem_we=0. dmem_rdata is registered into rbuf at the cycle-ending edge. Then load -> RESP, sub-word store -> WRITE.
- WRITE: dmem_we=1 for exactly one cycle, same aligned dmem_addr.
  - Word store: dmem_wdata = wdata.
  - Byte store: rbuf with lane addr[1:0] replaced by wdata[7:0].
  - Half store: rbuf with lanes {addr[1],1}:{addr[1],0} replaced by wdata[15:0].
  - Then -> RESP.
- Lane map: byte lane k = bits [8k+7:8k]. Lane 0 is the lowest address.
- Load extraction from rbuf:
  - Byte: lane addr[1:0].
  - Half: lanes selected by addr[1].
  - Bit 7 (byte) or bit 15 (half) is replicated to 32 bits unless unsigned.
  - Word is passed through.
- RESP: resp_valid=1. resp_rdata and resp_err stay stable until an edge with resp_ready=1, then -> IDLE. No new request is accepted in the same cycle (req_ready=0 in RESP).
- Latency, accept edge = cycle 0; resp_valid first high in cycle:
  - misaligned: 1
  - load: 2
  - word store: 2
  - sub-word store: 3
- dmem_we is low in every state except WRITE. No write ever occurs for loads or errors.
- Reset mid-operation:
  - rst sampled during READ: no write occurs.
  - rst sampled at the edge ending WRITE: the memory write still commits, because memory has no reset. The block returns to IDLE and no response is issued.
  - A pending response is discarded by reset.
- dmem_addr/dmem_wdata hold their last values outside READ/WRITE; only dmem_we qualifies them.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding;
  - function lane_merge(word, data, addr_lo, size);
  - function load_extend(word, addr_lo, size, unsigned).
- One natural sub-module: lsu_lane_unit. Purely combinational merge and extract, shared with a later instruction-fetch path. The FSM stays in lsu_dmem_master.

Test Plan:
- Preload 0x10 = 0xDEADBEEF:
  - lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE;
  - lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF;
  - each resp_valid at cycle 2, dmem_we never high.
- sb 0x11 wdata 0x12345655 -> memory word 0x10 = 0xDEAD55EF, one dmem_we pulse (cycle 2, dmem_addr 0x10), resp at cycle 3, resp_rdata 0.
- sh 0x12 0x0000CAFE then lw 0x10 -> 0xCAFEBEEF; sw 0x14 0x01020304 then lbu 0x15 -> 0x00000003.
- sh 0x11 and lw 0x12 -> resp_err=1 at cycle 1, resp_rdata 0, memory unchanged, dmem_we never high.
- Hold resp_ready low 5 cycles after lw 0x10 -> resp_valid/resp_rdata stable at 0xDEADBEEF, req_ready 0 throughout; IDLE one cycle after the resp_ready edge.
- Assert rst in the READ cycle of sb 0x10 0xAA -> memory stays 0xDEADBEEF, no response, req_ready=1 next cycle.
